// File: rtl/pipe_rca.sv
// -----------------------------------------------------------------------------
// pipe_rca -- pipelined, parametrised ripple-carry adder with valid/ready flow.
//
// A WIDTH-bit add is split into STAGES = WIDTH/SEG ripple segments. Stage k
// resolves bits [k*SEG +: SEG] and registers the growing partial sum together
// with its segment carry-out. Operand bits not yet consumed travel down the
// pipe (skewed) next to the partial sum. The last stage's registers drive the
// outputs directly, so sum/cout/out_valid are flop outputs.
//
// Flow control: the whole pipe advances together when the output slot is
// empty or being consumed (advance = !out_valid || out_ready). A stall freezes
// every stage, so results leave strictly in acceptance order with bubbles
// preserved. Full throughput is one add per cycle.
//
// Parameters:
//   WIDTH  operand/sum width, must be a multiple of SEG
//   SEG    bits resolved per stage (ripple length per stage), SEG >= 1
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears every stage)
//   in_valid   operands a/b/cin valid
//   in_ready   block accepts operands this cycle (== advance)
//   a, b       unsigned operands
//   cin        carry in
//   out_valid  result valid (registered)
//   out_ready  consumer accepts result
//   sum        low WIDTH bits of a+b+cin (registered)
//   cout       carry out of bit WIDTH-1 (registered)
//   ovf        signed overflow of a+b+cin, only with PIPE_RCA_OVF_EN
//
// Optional feature macro: PIPE_RCA_OVF_EN
//   When defined, adds the registered output ovf = carry-into-MSB XOR
//   carry-out-of-MSB, aligned with sum, reset to 0 and held under stall.
// -----------------------------------------------------------------------------
module pipe_rca #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_RCA_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Guarded so a bad SEG cannot cause a divide-by-zero before the check fires.
  localparam int STAGES = (SEG < 1) ? 1 : (WIDTH / SEG);

  // Elaboration-time parameter sanity check.
  if (SEG < 1) begin : g_bad_seg
    $fatal(1, "pipe_rca: SEG must be >= 1");
  end else if ((WIDTH % SEG) != 0) begin : g_bad_width
    $fatal(1, "pipe_rca: WIDTH must be a multiple of SEG");
  end

  // One SEG-bit ripple-carry segment; returns {carry_out, sum}.
  function automatic logic [SEG:0] seg_add(
    input logic [SEG-1:0] x,
    input logic [SEG-1:0] y,
    input logic           ci
  );
    logic [SEG:0]   c;
    logic [SEG-1:0] s;
    c[0] = ci;
    for (int i = 0; i < SEG; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    return {c[SEG], s};
  endfunction

  logic adv_s;
  logic last_vld_s;

  // The pipe moves as one unit; a full output slot that is not taken holds all.
  assign adv_s    = !last_vld_s || out_ready;
  assign in_ready = adv_s;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG;       // first bit resolved by this stage
    localparam int IW = WIDTH - LO;    // operand bits still unresolved on entry

    // Stage inputs: operands (unresolved part), carry and valid from upstream.
    logic [IW-1:0]     src_a_s;
    logic [IW-1:0]     src_b_s;
    logic              src_c_s;
    logic              src_vld_s;
    logic [LO+SEG-1:0] psum_next_s;
    logic [SEG:0]      seg_res_s;
    logic              load_s;

    logic              vld_d,   vld_q;
    logic [LO+SEG-1:0] psum_d,  psum_q;
    logic              carry_d, carry_q;

    if (k == 0) begin : g_head
      assign src_a_s     = a;
      assign src_b_s     = b;
      assign src_c_s     = cin;
      assign src_vld_s   = in_valid;
      assign psum_next_s = seg_res_s[SEG-1:0];
    end else begin : g_body
      // Forwarded operand bits, loaded together with the previous stage's sum.
      logic [IW-1:0] opa_d, opa_q;
      logic [IW-1:0] opb_d, opb_q;

      // Capture the still-unresolved operand bits when the upstream slot loads.
      always_comb begin
        opa_d = opa_q;
        opb_d = opb_q;
        if (g_stage[k-1].load_s) begin
          opa_d = g_stage[k-1].src_a_s[IW+SEG-1:SEG];
          opb_d = g_stage[k-1].src_b_s[IW+SEG-1:SEG];
        end else begin
          opa_d = opa_q;
          opb_d = opb_q;
        end
      end

      // Forwarded operand registers.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          opa_q <= '0;
          opb_q <= '0;
        end else begin
          opa_q <= opa_d;
          opb_q <= opb_d;
        end
      end

      assign src_a_s     = opa_q;
      assign src_b_s     = opb_q;
      assign src_c_s     = g_stage[k-1].carry_q;
      assign src_vld_s   = g_stage[k-1].vld_q;
      assign psum_next_s = {seg_res_s[SEG-1:0], g_stage[k-1].psum_q};
    end

    assign seg_res_s = seg_add(src_a_s[SEG-1:0], src_b_s[SEG-1:0], src_c_s);

    // Data only moves on a real operation; bubbles leave the data regs alone.
    assign load_s = adv_s && src_vld_s;

    // Next-state for this stage's valid bit, partial sum and carry.
    always_comb begin
      vld_d   = vld_q;
      psum_d  = psum_q;
      carry_d = carry_q;
      if (adv_s) begin
        vld_d = src_vld_s;
      end else begin
        vld_d = vld_q;
      end
      if (load_s) begin
        psum_d  = psum_next_s;
        carry_d = seg_res_s[SEG];
      end else begin
        psum_d  = psum_q;
        carry_d = carry_q;
      end
    end

    // Stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q   <= 1'b0;
        psum_q  <= '0;
        carry_q <= 1'b0;
      end else begin
        vld_q   <= vld_d;
        psum_q  <= psum_d;
        carry_q <= carry_d;
      end
    end
  end

  assign last_vld_s = g_stage[STAGES-1].vld_q;
  assign out_valid  = last_vld_s;
  assign sum        = g_stage[STAGES-1].psum_q;
  assign cout       = g_stage[STAGES-1].carry_q;

`ifdef PIPE_RCA_OVF_EN
  logic ovf_d, ovf_q;
  logic msb_cin_s;

  // Carry into the MSB recovered from the MSB sum bit: c = a ^ b ^ s.
  assign msb_cin_s = g_stage[STAGES-1].src_a_s[SEG-1] ^
                     g_stage[STAGES-1].src_b_s[SEG-1] ^
                     g_stage[STAGES-1].seg_res_s[SEG-1];

  // Overflow flag loads with the final segment so it stays aligned with sum.
  always_comb begin
    ovf_d = ovf_q;
    if (g_stage[STAGES-1].load_s) begin
      ovf_d = msb_cin_s ^ g_stage[STAGES-1].seg_res_s[SEG];
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule
